unique_stats_engine: RTL



---
 rtl/unique_stats_pkg.sv | 27 ++
 rtl/unique_stats_engine_peasant_mult_seq.sv | 60 ++++++
 rtl/unique_stats_engine.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/unique_stats_pkg.sv
// rtl/unique_stats_pkg.sv - shared types and constants for the unique statistics engine
//
// Purpose: element/accumulator widths, iteration count, FSM state encoding and
//          the element-count clamp shared by the engine and its multiplier.
package unique_stats_pkg;

  localparam int DATA_W    = 8;
  localparam int MAX_ELEM  = 9;
  localparam int SUM_W     = DATA_W + 4;
  localparam int SQ_W      = 2 * DATA_W + 4;
  localparam int MUL_ITERS = 8;
  localparam int CNT_W     = 4;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    MUL,
    ACC,
    DONE
  } state_t;

  // Counts above the slot count are clamped; the overflow is reported separately.
  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
    return (c > CNT_W'(MAX_ELEM)) ? CNT_W'(MAX_ELEM) : c;
  endfunction

endpackage

// File: rtl/unique_stats_engine_peasant_mult_seq.sv
// rtl/unique_stats_engine_peasant_mult_seq.sv - sequential shift-add 8x8 multiplier
//
// Purpose: computes a*b in exactly MUL_ITERS cycles after a start pulse.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           load operands and clear the product (1 cycle)
//   a, b            multiplicand and multiplier, sampled on start
//   done            1-cycle pulse during the cycle of the final iteration;
//                   product is final from the following edge
//   product         16-bit running / final product
module peasant_mult_seq
  import unique_stats_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  logic [2*DATA_W-1:0] mcand_q;
  logic [2*DATA_W-1:0] prod_q;
  logic [DATA_W-1:0]   mplier_q;
  logic [2:0]          iter_q;
  logic                busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      iter_q   <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      mcand_q  <= {{DATA_W{1'b0}}, a};
      mplier_q <= b;
      prod_q   <= '0;
      iter_q   <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        prod_q <= prod_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      iter_q   <= iter_q + 3'd1;
      if (iter_q == 3'(MUL_ITERS - 1)) begin
        busy_q <= 1'b0;
      end
    end
  end

  // Signalled during the last iteration so the parent can leave MUL on the
  // same edge that writes the final product.
  assign done    = busy_q && (iter_q == 3'(MUL_ITERS - 1));
  assign product = prod_q;

endmodule

// File: rtl/unique_stats_engine.sv
// rtl/unique_stats_engine.sv - min/max/range/sum/sum-of-squares over one deduplicated frame
//
// Purpose: accepts up to nine unique values plus a count, walks them one at a
//          time (8 multiply cycles + 1 accumulate cycle each) and presents the
//          statistics on a valid/ready handshake.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      frame handshake; in_ready is high only in IDLE
//   in1..in9, in_count       element values and number of valid elements
//   out_valid / out_ready    result handshake; results held while stalled
//   min_val, max_val         smallest / largest valid element
//   range_val                max_val - min_val
//   sum, sum_sq              sum and sum of squares of valid elements
//   out_count, cnt_err       clamped count used, and in_count > 9 flag
module unique_stats_engine
  import unique_stats_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [DATA_W-1:0] in4,
  input  logic [DATA_W-1:0] in5,
  input  logic [DATA_W-1:0] in6,
  input  logic [DATA_W-1:0] in7,
  input  logic [DATA_W-1:0] in8,
  input  logic [DATA_W-1:0] in9,
  input  logic [CNT_W-1:0]  in_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] min_val,
  output logic [DATA_W-1:0] max_val,
  output logic [DATA_W-1:0] range_val,
  output logic [SUM_W-1:0]  sum,
  output logic [SQ_W-1:0]   sum_sq,
  output logic [CNT_W-1:0]  out_count,
  output logic              cnt_err
);

  state_t state_q, state_d;

  logic [DATA_W-1:0]   elem_q [MAX_ELEM];
  logic [CNT_W-1:0]    n_q;
  logic [CNT_W-1:0]    idx_q;
  logic                err_q;
  logic [SUM_W-1:0]    acc_sum_q;
  logic [SQ_W-1:0]     acc_sq_q;
  logic [DATA_W-1:0]   acc_min_q;
  logic [DATA_W-1:0]   acc_max_q;

  logic                mul_start;
  logic [CNT_W-1:0]    mul_idx;
  logic                mul_done;
  logic [2*DATA_W-1:0] mul_product;

  logic                accept;
  logic                last_elem;
  logic [DATA_W-1:0]   elem_cur;
  logic [SUM_W-1:0]    sum_nx;
  logic [SQ_W-1:0]     sq_nx;
  logic [DATA_W-1:0]   min_nx;
  logic [DATA_W-1:0]   max_nx;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_ready && in_valid;
  assign last_elem = ((idx_q + CNT_W'(1)) == n_q);

  // Squaring: the element is both multiplicand and multiplier.
  peasant_mult_seq u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (elem_q[mul_idx]),
    .b       (elem_q[mul_idx]),
    .done    (mul_done),
    .product (mul_product)
  );

  // Values produced by the ACC cycle for the element at idx_q.
  assign elem_cur = elem_q[idx_q];
  assign sum_nx   = acc_sum_q + SUM_W'(elem_cur);
  assign sq_nx    = acc_sq_q + SQ_W'(mul_product);
  assign min_nx   = (elem_cur < acc_min_q) ? elem_cur : acc_min_q;
  assign max_nx   = (elem_cur > acc_max_q) ? elem_cur : acc_max_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The multiplier is started on the edge that enters MUL, so its eight
  // iterations line up exactly with the eight MUL cycles.
  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    mul_idx   = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (n_q == '0) begin
          state_d = DONE;
        end else begin
          state_d   = MUL;
          mul_start = 1'b1;
          mul_idx   = '0;
        end
      end
      MUL: begin
        if (mul_done) begin
          state_d = ACC;
        end
      end
      ACC: begin
        if (last_elem) begin
          state_d = DONE;
        end else begin
          state_d   = MUL;
          mul_start = 1'b1;
          mul_idx   = idx_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_ELEM; i++) begin
        elem_q[i] <= '0;
      end
      n_q       <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      acc_sum_q <= '0;
      acc_sq_q  <= '0;
      acc_min_q <= '0;
      acc_max_q <= '0;
      min_val   <= '0;
      max_val   <= '0;
      range_val <= '0;
      sum       <= '0;
      sum_sq    <= '0;
      out_count <= '0;
      cnt_err   <= 1'b0;
    end else begin
      if (accept) begin
        elem_q[0] <= in1;
        elem_q[1] <= in2;
        elem_q[2] <= in3;
        elem_q[3] <= in4;
        elem_q[4] <= in5;
        elem_q[5] <= in6;
        elem_q[6] <= in7;
        elem_q[7] <= in8;
        elem_q[8] <= in9;
        n_q       <= clamp_count(in_count);
        err_q     <= (in_count > CNT_W'(MAX_ELEM));
        idx_q     <= '0;
        acc_sum_q <= '0;
        acc_sq_q  <= '0;
        acc_min_q <= '1;
        acc_max_q <= '0;
      end

      // Empty frame: min would otherwise report the 8'hFF seed.
      if ((state_q == CAPTURE) && (n_q == '0)) begin
        min_val   <= '0;
        max_val   <= '0;
        range_val <= '0;
        sum       <= '0;
        sum_sq    <= '0;
        out_count <= '0;
        cnt_err   <= err_q;
      end

      if (state_q == ACC) begin
        acc_sum_q <= sum_nx;
        acc_sq_q  <= sq_nx;
        acc_min_q <= min_nx;
        acc_max_q <= max_nx;
        idx_q     <= idx_q + CNT_W'(1);
        if (last_elem) begin
          min_val   <= min_nx;
          max_val   <= max_nx;
          range_val <= max_nx - min_nx;
          sum       <= sum_nx;
          sum_sq    <= sq_nx;
          out_count <= n_q;
          cnt_err   <= err_q;
        end
      end
    end
  end

endmodule
